// File: rtl/uart_pio.sv
// Memory-mapped UART at $FB20-$FB23: 4-deep TX/RX FIFOs, programmable bit divisor,
// level interrupt. Bus actions fire once on the rising edge of the registered strobe.
module uart_pio #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  DIV_RESET  = 8'd233
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rs,
  input  logic       en,
  input  logic       wren,
  input  logic       rden,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       txd,
  input  logic       rxd,
  output logic       interrupt
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t  tx_state;
  rx_state_t  rx_state;
  logic       acc_wr, acc_wr_d, acc_rd, acc_rd_d, wr_fire, rd_fire;
  logic [1:0] rs_q;
  logic [7:0] din_q, div;
  logic       rx_ie, tx_ie, tx_ovf, rx_ovr, rx_ferr;
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       tx_push, tx_pop, tx_ovf_set, rx_push, rx_pop, rx_ovr_set, rx_ferr_set, stat_clr;
  logic [7:0] tx_tmr, tx_shift, rx_tmr, rx_shift;
  logic [2:0] tx_cnt, rx_cnt;
  logic       tx_busy, rx_s1, rx_s2, rx_prev;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign tx_busy  = (tx_state != TX_IDLE);
  assign wr_fire  = acc_wr & ~acc_wr_d;
  assign rd_fire  = acc_rd & ~acc_rd_d;

  always_comb begin
    tx_pop      = ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_tmr == '0)) && !tx_empty;
    tx_push     = wr_fire && (rs_q == 2'd0) && (!tx_full || tx_pop);
    tx_ovf_set  = wr_fire && (rs_q == 2'd0) && tx_full && !tx_pop;
    rx_pop      = rd_fire && (rs_q == 2'd0) && !rx_empty;
    stat_clr    = rd_fire && (rs_q == 2'd1);
    rx_push     = (rx_state == RX_STOP) && (rx_tmr == '0) && rx_s2 && (!rx_full || rx_pop);
    rx_ovr_set  = (rx_state == RX_STOP) && (rx_tmr == '0) && rx_s2 && rx_full && !rx_pop;
    rx_ferr_set = (rx_state == RX_STOP) && (rx_tmr == '0) && !rx_s2;
  end

  always_comb begin
    data_out = '0;
    if (en && rden) begin
      case (rs)
        2'd0:    data_out = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];
        2'd1:    data_out = {2'b00, tx_busy, rx_ferr, rx_ovr, ~rx_empty, tx_empty, tx_full};
        2'd2:    data_out = div;
        default: data_out = {6'b0, tx_ie, rx_ie};
      endcase
    end
  end

  // rs/data are captured with the strobe so the delayed fire still sees the first-cycle values
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_wr <= 1'b0; acc_wr_d <= 1'b0; acc_rd <= 1'b0; acc_rd_d <= 1'b0;
      rs_q <= '0; din_q <= '0; div <= DIV_RESET;
      rx_ie <= 1'b0; tx_ie <= 1'b0;
      tx_ovf <= 1'b0; rx_ovr <= 1'b0; rx_ferr <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      acc_wr   <= en & wren;
      acc_wr_d <= acc_wr;
      acc_rd   <= en & rden;
      acc_rd_d <= acc_rd;
      rs_q     <= rs;
      din_q    <= data_in;
      if (wr_fire && rs_q == 2'd2) div <= din_q;
      if (wr_fire && rs_q == 2'd3) begin
        rx_ie <= din_q[0];
        tx_ie <= din_q[1];
      end
      tx_ovf    <= (tx_ovf & ~stat_clr) | tx_ovf_set;
      rx_ovr    <= (rx_ovr & ~stat_clr) | rx_ovr_set;
      rx_ferr   <= (rx_ferr & ~stat_clr) | rx_ferr_set;
      interrupt <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty & ~tx_busy);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp <= '0; tx_rp <= '0; rx_wp <= '0; rx_rp <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp[AW-1:0]] <= din_q;
        tx_wp <= tx_wp + 1'b1;
      end
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      if (rx_push) begin
        rx_mem[rx_wp[AW-1:0]] <= rx_shift;
        rx_wp <= rx_wp + 1'b1;
      end
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE; txd <= 1'b1; tx_tmr <= '0; tx_cnt <= '0; tx_shift <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: if (tx_pop) begin
          tx_shift <= tx_mem[tx_rp[AW-1:0]]; tx_cnt <= '0; tx_tmr <= div;
          txd <= 1'b0; tx_state <= TX_START;
        end
        TX_START: if (tx_tmr == '0) begin
          tx_tmr <= div; txd <= tx_shift[0]; tx_state <= TX_DATA;
        end else tx_tmr <= tx_tmr - 8'd1;
        TX_DATA: if (tx_tmr == '0) begin
          tx_tmr <= div;
          if (tx_cnt == 3'd7) begin
            txd <= 1'b1; tx_state <= TX_STOP;
          end else begin
            txd <= tx_shift[1]; tx_shift <= tx_shift >> 1; tx_cnt <= tx_cnt + 3'd1;
          end
        end else tx_tmr <= tx_tmr - 8'd1;
        TX_STOP: if (tx_tmr == '0) begin
          if (tx_pop) begin
            tx_shift <= tx_mem[tx_rp[AW-1:0]]; tx_cnt <= '0; tx_tmr <= div;
            txd <= 1'b0; tx_state <= TX_START;
          end else tx_state <= TX_IDLE;
        end else tx_tmr <= tx_tmr - 8'd1;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE; rx_tmr <= '0; rx_cnt <= '0; rx_shift <= '0;
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_s2) begin
          rx_tmr <= div >> 1; rx_state <= RX_START;
        end
        RX_START: if (rx_tmr == '0) begin
          rx_tmr <= div; rx_cnt <= '0;
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
        end else rx_tmr <= rx_tmr - 8'd1;
        RX_DATA: if (rx_tmr == '0) begin
          rx_tmr <= div; rx_shift <= {rx_s2, rx_shift[7:1]};
          if (rx_cnt == 3'd7) rx_state <= RX_STOP;
          else rx_cnt <= rx_cnt + 3'd1;
        end else rx_tmr <= rx_tmr - 8'd1;
        RX_STOP: if (rx_tmr == '0) rx_state <= RX_IDLE;
          else rx_tmr <= rx_tmr - 8'd1;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule
